// File: rtl/alu_addsub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor with a carry chain split into SEGMENTS register stages.
// Optional zero/overflow flags are built when ALU_FLAGS_EN is defined.
module alu_addsub_pipe #(
    parameter int WIDTH    = 16,
    parameter int SEGMENTS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_result
`ifdef ALU_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_ovf
`endif
);

    localparam int S  = SEGMENTS;
    localparam int SW = WIDTH / SEGMENTS;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; a stage loads whenever it is empty or its content moves on.
    logic             vld_q [S];
    logic             op_q  [S];
    logic             cy_q  [S];
    logic [WIDTH-1:0] a_q   [S];
    logic [WIDTH-1:0] b_q   [S];
    logic [WIDTH-1:0] r_q   [S];

    logic [S:0]       take;

    logic             src_vld [S];
    logic             src_op  [S];
    logic             src_cin [S];
    logic [WIDTH-1:0] src_a   [S];
    logic [WIDTH-1:0] src_b   [S];
    logic [WIDTH-1:0] src_r   [S];
    logic [WIDTH-1:0] nxt_r   [S];
    logic             nxt_c   [S];

    always_comb begin
        take    = '0;
        take[S] = out_ready;
        for (int k = S - 1; k >= 0; k--) begin
            take[k] = !vld_q[k] || take[k+1];
        end
        in_ready = take[0];
    end

    // Each stage adds one operand slice using the carry registered by the previous stage.
    always_comb begin
        logic [SW-1:0] bx;
        logic [SW:0]   sum;
        bx  = '0;
        sum = '0;

        src_vld[0] = in_valid;
        src_op[0]  = in_op;
        src_cin[0] = in_op;
        src_a[0]   = in_a;
        src_b[0]   = in_b;
        src_r[0]   = '0;
        for (int k = 1; k < S; k++) begin
            src_vld[k] = vld_q[k-1];
            src_op[k]  = op_q[k-1];
            src_cin[k] = cy_q[k-1];
            src_a[k]   = a_q[k-1];
            src_b[k]   = b_q[k-1];
            src_r[k]   = r_q[k-1];
        end

        for (int k = 0; k < S; k++) begin
            bx  = src_op[k] ? ~src_b[k][k*SW +: SW] : src_b[k][k*SW +: SW];
            sum = {1'b0, src_a[k][k*SW +: SW]} + {1'b0, bx} + {{SW{1'b0}}, src_cin[k]};
            nxt_r[k]              = src_r[k];
            nxt_r[k][k*SW +: SW]  = sum[SW-1:0];
            nxt_c[k]              = sum[SW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < S; k++) begin
                vld_q[k] <= 1'b0;
                op_q[k]  <= 1'b0;
                cy_q[k]  <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                r_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < S; k++) begin
                if (take[k]) begin
                    vld_q[k] <= src_vld[k];
                    if (src_vld[k]) begin
                        op_q[k] <= src_op[k];
                        cy_q[k] <= nxt_c[k];
                        a_q[k]  <= src_a[k];
                        b_q[k]  <= src_b[k];
                        r_q[k]  <= nxt_r[k];
                    end
                end
            end
        end
    end

    // For subtract the top bit is the inverted final carry (set when A < B).
    assign out_valid  = vld_q[S-1];
    assign out_result = {op_q[S-1] ^ cy_q[S-1], r_q[S-1]};

`ifdef ALU_FLAGS_EN
    logic zero_q;
    logic ovf_q;
    logic zero_nxt;
    logic ovf_nxt;

    always_comb begin
        logic a_msb;
        logic b_msb;
        logic r_msb;
        a_msb    = src_a[S-1][WIDTH-1];
        b_msb    = src_b[S-1][WIDTH-1];
        r_msb    = nxt_r[S-1][WIDTH-1];
        zero_nxt = (nxt_r[S-1] == '0);
        if (src_op[S-1]) begin
            ovf_nxt = (a_msb != b_msb) && (r_msb != a_msb);
        end else begin
            ovf_nxt = (a_msb == b_msb) && (r_msb != a_msb);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (take[S-1] && src_vld[S-1]) begin
            zero_q <= zero_nxt;
            ovf_q  <= ovf_nxt;
        end
    end

    assign out_zero = zero_q;
    assign out_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_alu_addsub_pipe.sv
// Scoreboard bench for alu_addsub_pipe at WIDTH=16 with SEGMENTS in {2,1,4,16}.
// Each instance runs the directed cases, a stall/drain case, a mid-flight reset and random traffic.
module tb_alu_addsub_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input int s, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL S=%0d %s got=%h required=%h", s, name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    function automatic logic [16:0] ref_res(input bit op, input logic [15:0] a, input logic [15:0] b);
        int r;
        r = op ? (int'(a) - int'(b)) : (int'(a) + int'(b));
        return r[16:0];
    endfunction

    function automatic bit ref_zero(input bit op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] r;
        r = ref_res(op, a, b);
        return (r[15:0] == 16'h0);
    endfunction

    function automatic bit ref_ovf(input bit op, input logic [15:0] a, input logic [15:0] b);
        int sa;
        int sb;
        int s;
        sa = $signed(a);
        sb = $signed(b);
        s  = op ? (sa - sb) : (sa + sb);
        return (s > 32767) || (s < -32768);
    endfunction

    for (genvar g = 0; g < 4; g++) begin : u
        localparam int S = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 16;

        logic        rst;
        logic        in_valid;
        logic        in_op;
        logic [15:0] in_a;
        logic [15:0] in_b;
        logic        out_ready;
        logic        in_ready;
        logic        out_valid;
        logic [16:0] out_result;
`ifdef ALU_FLAGS_EN
        logic        out_zero;
        logic        out_ovf;
`endif
        bit          rand_rdy = 1'b0;
        bit          done     = 1'b0;
        int          cyc      = 0;

        logic [16:0] exp_q[$];
        int          cyc_q[$];
        bit          lat_q[$];
        bit          ez_q[$];
        bit          eo_q[$];

        alu_addsub_pipe #(.WIDTH(16), .SEGMENTS(S)) dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid),
            .in_ready   (in_ready),
            .in_op      (in_op),
            .in_a       (in_a),
            .in_b       (in_b),
            .out_valid  (out_valid),
            .out_ready  (out_ready),
            .out_result (out_result)
`ifdef ALU_FLAGS_EN
            ,
            .out_zero   (out_zero),
            .out_ovf    (out_ovf)
`endif
        );

        always @(posedge clk) cyc <= cyc + 1;

        initial begin
            forever begin
                @(posedge clk);
                #1;
                if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            end
        end

        // Monitor: compare the head of the queue whenever a result is presented.
        always @(negedge clk) begin
            if (!rst && out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL S=%0d unexpected_output got=%h required=none", S, out_result);
                end else begin
                    check(S, "result", 32'(out_result), 32'(exp_q[0]));
`ifdef ALU_FLAGS_EN
                    check(S, "zero", 32'(out_zero), 32'(ez_q[0]));
                    check(S, "ovf", 32'(out_ovf), 32'(eo_q[0]));
`endif
                    if (out_ready) begin
                        if (lat_q[0]) check(S, "latency", cyc - cyc_q[0], S);
                        void'(exp_q.pop_front());
                        void'(cyc_q.pop_front());
                        void'(lat_q.pop_front());
                        void'(ez_q.pop_front());
                        void'(eo_q.pop_front());
                    end
                end
            end
        end

        task automatic send(input bit op, input logic [15:0] a, input logic [15:0] b,
                            input logic [16:0] er, input bit ez, input bit eo, input bit lat);
            in_valid = 1'b1;
            in_op    = op;
            in_a     = a;
            in_b     = b;
            for (int t = 0; t < 300; t++) begin
                @(negedge clk);
                if (in_ready) begin
                    exp_q.push_back(er);
                    cyc_q.push_back(cyc);
                    lat_q.push_back(lat);
                    ez_q.push_back(ez);
                    eo_q.push_back(eo);
                    @(posedge clk);
                    #1;
                    in_valid = 1'b0;
                    return;
                end
                @(posedge clk);
                #1;
            end
            checks++;
            failures++;
            $display("FAIL S=%0d send_timeout got=no_accept required=accept", S);
            in_valid = 1'b0;
        endtask

        task automatic send_rand(input bit lat);
            bit          op;
            logic [15:0] a;
            logic [15:0] b;
            op = 1'($urandom_range(0, 1));
            a  = 16'($urandom);
            b  = 16'($urandom);
            if ($urandom_range(0, 7) == 0) b = a;
            send(op, a, b, ref_res(op, a, b), ref_zero(op, a, b), ref_ovf(op, a, b), lat);
        endtask

        task automatic drain();
            for (int t = 0; t < 400; t++) begin
                if (exp_q.size() == 0) break;
                @(posedge clk);
            end
            #1;
            check(S, "drain_empty", exp_q.size(), 0);
        endtask

        initial begin
            rst       = 1'b1;
            in_valid  = 1'b0;
            in_op     = 1'b0;
            in_a      = '0;
            in_b      = '0;
            out_ready = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            check(S, "rst_out_valid", 32'(out_valid), 0);
            check(S, "rst_out_result", 32'(out_result), 0);
`ifdef ALU_FLAGS_EN
            check(S, "rst_zero", 32'(out_zero), 0);
            check(S, "rst_ovf", 32'(out_ovf), 0);
`endif
            rst = 1'b0;
            @(negedge clk);
            check(S, "in_ready_after_rst", 32'(in_ready), 1);
            @(posedge clk);
            #1;

            // Directed values and boundaries, unstalled, latency checked.
            send(1'b1, 16'd60003, 16'd43839, 17'h03F24, 1'b0, 1'b0, 1'b1);
            drain();
            send(1'b1, 16'd24485, 16'd56623, 17'h18276, 1'b0, 1'b1, 1'b1);
            send(1'b0, 16'd60003, 16'd43839, 17'h195A2, 1'b0, 1'b0, 1'b1);
            send(1'b0, 16'h7FFF, 16'h0001, 17'h08000, 1'b0, 1'b1, 1'b1);
            send(1'b1, 16'h1234, 16'h1234, 17'h00000, 1'b1, 1'b0, 1'b1);
            send(1'b1, 16'hABCD, 16'hABCD, 17'h00000, 1'b1, 1'b0, 1'b1);
            send(1'b0, 16'hFFFF, 16'hFFFF, 17'h1FFFE, 1'b0, 1'b0, 1'b1);
            send(1'b1, 16'h0000, 16'hFFFF, 17'h10001, 1'b0, 1'b0, 1'b1);
            drain();

            // Stall: S accepts fill the pipe, then in_ready must drop and the output hold.
            out_ready = 1'b0;
            for (int i = 0; i < S; i++) send_rand(1'b0);
            in_valid = 1'b1;
            in_op    = 1'b0;
            in_a     = 16'h0F0F;
            in_b     = 16'h00F1;
            @(negedge clk);
            check(S, "in_ready_full", 32'(in_ready), 0);
            check(S, "out_valid_stall", 32'(out_valid), 1);
            repeat (3) begin
                @(posedge clk);
                #1;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            for (int i = 0; i < 3; i++) send_rand(1'b0);
            drain();

            // Reset with transactions in flight discards them.
            send_rand(1'b0);
            send_rand(1'b0);
            rst = 1'b1;
            #1;
            check(S, "midrst_out_valid", 32'(out_valid), 0);
            check(S, "midrst_out_result", 32'(out_result), 0);
            exp_q.delete();
            cyc_q.delete();
            lat_q.delete();
            ez_q.delete();
            eo_q.delete();
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(posedge clk);
            #1;
            send(1'b0, 16'd1, 16'd1, 17'h00002, 1'b0, 1'b0, 1'b1);
            drain();

            // Random, unstalled back-to-back: exact latency.
            for (int i = 0; i < 20; i++) send_rand(1'b1);
            drain();

            // Random with random out_ready and idle gaps.
            rand_rdy = 1'b1;
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                send_rand(1'b0);
            end
            rand_rdy = 1'b0;
            @(posedge clk);
            #2;
            out_ready = 1'b1;
            drain();
            done = 1'b1;
        end
    end

    initial begin
        for (int t = 0; t < 60000; t++) begin
            if (u[0].done && u[1].done && u[2].done && u[3].done) break;
            @(posedge clk);
        end
        if (!(u[0].done && u[1].done && u[2].done && u[3].done)) begin
            checks++;
            failures++;
            $display("FAIL global_timeout got=not_done required=done");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_addsub_pipe.md
Name: alu_addsub_pipe

Overview:
- Parametrised, pipelined successor to the 16-bit combinational subtractor: adds or subtracts two WIDTH-bit unsigned operands per transaction.
- Returns a WIDTH+1-bit result: carry for add, borrow/sign for subtract.
- The carry chain is split into SEGMENTS register stages, giving timing closure at wide WIDTH.
- Valid/ready handshakes on both sides, so the block sits between the MIPS-32 decode stage and the writeback arbiter.

Parameters:
- WIDTH, 16: operand width in bits; must be divisible by SEGMENTS.
- SEGMENTS, 2: number of carry-chain segments, which equals the pipeline depth; legal values 1..WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand transaction present.
- in_ready  output  1  block accepts a transaction this cycle.
- in_op  input  1  0 = add (A+B), 1 = subtract (A-B).
- in_a  input  WIDTH  operand A, unsigned.
- in_b  input  WIDTH  operand B, unsigned.
- out_valid  output  1  result present.
- out_ready  input  1  downstream consumes the result.
- out_result  output  WIDTH+1  result, defined under Behaviour.
- out_zero  output  1  low WIDTH bits of the result are all zero (ALU_FLAGS_EN only).
- out_ovf  output  1  signed two's-complement overflow of the WIDTH-bit operation (ALU_FLAGS_EN only).

Behaviour:
- Reset: every stage valid bit clears to 0. out_valid=0, out_result=0, out_zero=0, out_ovf=0. in_ready=1 from the first cycle after reset deasserts. Reset mid-operation discards every in-flight transaction; no partial result is ever presented.
- Arithmetic: subtract is computed as A + ~B + 1.
  - Add: out_result = A + B, zero-extended to WIDTH+1 bits; the MSB is the carry-out.
  - Subtract: out_result = (A - B) mod 2^(WIDTH+1). The MSB is 1 exactly when A < B, i.e. it is the inverted final carry.
- Segmentation: stage k (k = 0..SEGMENTS-1) computes result bits [(k+1)*W/S-1 : k*W/S] from the registered carry of stage k-1.
  - Stage 0 takes carry-in = in_op.
  - Upper operand slices and the op bit are carried forward in pipeline registers; lower result slices are carried forward already computed.
- Latency and throughput: exactly SEGMENTS cycles from the accept edge (in_valid & in_ready) to out_valid=1, with no stalls. Throughput is one transaction per cycle.
- Handshake:
  - A transaction transfers on a rising edge where valid & ready are both high.
  - Each stage advances when its successor is empty or advancing. in_ready = !stage0_valid | stage0_advances, computed combinationally from the pipeline state and out_ready.
  - out_valid, out_result and the flags hold stable while out_valid=1 and out_ready=0.
  - Ordering is strictly FIFO; no transaction is dropped or duplicated.
- Simultaneous events:
  - A full pipeline with out_ready=1 and in_valid=1 accepts the new transaction and retires the oldest on the same edge.
  - A full pipeline with out_ready=0 deasserts in_ready.
- Boundaries:
  - Subtract with A=B gives 0, MSB 0.
  - Add with A=B=2^WIDTH-1 gives 2^(WIDTH+1)-2.
  - Subtract with A=0, B=2^WIDTH-1 gives 2^WIDTH+1 (0x10001 at WIDTH=16).
- SEGMENTS=1 is a single registered stage with latency 1.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- Defined: out_zero and out_ovf exist and are registered alongside out_result with identical latency and stall behaviour.
  - out_zero = (out_result[WIDTH-1:0] == 0).
  - out_ovf for add = (a_msb == b_msb) & (r_msb != a_msb).
  - out_ovf for subtract = (a_msb != b_msb) & (r_msb != a_msb).
  - Here r_msb is bit WIDTH-1 of the result.
- Undefined: both ports and all flag logic are absent. The datapath, latency and handshake are unchanged.

Test Plan:
- WIDTH=16, SEGMENTS=2, out_ready=1, sub A=60003 B=43839 -> out_result=0x03F24 (16164) exactly 2 cycles after accept.
- Sub A=24485 B=56623 -> out_result=0x18276, MSB=1. Add A=60003 B=43839 -> 0x195A2. Both issued back-to-back with results on consecutive cycles.
- ALU_FLAGS_EN, add A=0x7FFF B=0x0001 -> 0x08000, out_ovf=1, out_zero=0. Sub A=0x1234 B=0x1234 -> 0x00000, out_zero=1, out_ovf=0.
- Stream 5 transactions with out_ready held 0 -> in_ready falls after 2 accepts. Output holds the first result stable. Releasing out_ready drains all 5 in order, nothing lost.
- Assert rst for 1 cycle while 2 transactions are in flight -> out_valid=0 and out_result=0 immediately. The next accepted transaction (add 1+1) yields exactly 0x00002 after 2 cycles.
- Sweep SEGMENTS in {1,4,16}, WIDTH=16, 200 random ops with random out_ready -> every result matches the reference model, latency equals SEGMENTS when unstalled.
